prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter INSTR_BYTES, default 3, bytes per instruction word; word width is 8*INSTR_BYTES (24 by default).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  byte accepted on a cycle where in_valid and in_ready are both 1.
REQ-010 mem_w_enable  output  1  instruction-memory write strobe.
REQ-011 mem_w_addr  output  ADDR_W  write address.
REQ-012 mem_w_data  output  8*INSTR_BYTES  write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  last load completed with a good checksum.
REQ-015 error  output  1  last load completed with a bad checksum.

Function
REQ-016 SHALL implement an FSM with states IDLE, LEN, DATA and CHECK.
REQ-017 IDLE: in_ready=0; start=1 -> LEN, clear done/error, address counter=0, checksum=0, byte index=0.
REQ-018 LEN: in_ready=1; accepted byte -> word count N, checksum^=byte; N=0 -> CHECK, else -> DATA.
REQ-019 DATA: in_ready=1; accepted bytes fill the word MSB-first (first byte -> bits [8*INSTR_BYTES-1 -: 8]); checksum^=byte.
REQ-020 Final byte of a word accepted -> on the next cycle mem_w_enable=1 for exactly one cycle, with mem_w_addr=current counter and mem_w_data=assembled word.
REQ-021 After each write: counter+1 (wraps modulo 2^ADDR_W), words-remaining-1, byte index=0.
REQ-022 Last word (N-th) accepted -> CHECK.
REQ-023 in_ready SHALL stay 1 during the write cycle; the next word's first byte may be accepted in that same cycle without corrupting the write.
REQ-024 CHECK: in_ready=1; accepted byte compared with the running XOR; equal -> done=1, else error=1; then -> IDLE.
REQ-025 done/error SHALL hold until the next honoured start or reset; never both 1.
REQ-026 Cycles with in_valid=0 SHALL leave all state unchanged (gaps allowed between any bytes).
REQ-027 Bytes presented in IDLE SHALL be ignored.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 A bad checksum SHALL NOT retract writes already performed.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, in_ready=0, mem_w_enable=0, mem_w_addr=0, mem_w_data=0, busy=0, done=0, error=0, and clear counter, checksum and byte index.
REQ-031 Reset mid-load SHALL discard any partial word with no write; the next load restarts at address 0.

Structure
REQ-032 SHALL take the FSM state enum, INSTR_BYTES default and instruction width constant from the shared CPU package used by rom/decoder.
REQ-033 SHALL contain one sub-module, prog_packer: byte-index counter plus shift-in word register, asserting word_complete on the final byte.

Verification
REQ-034 start; bytes 01,12,34,56, checksum 71 -> one write addr 0x00 data 0x123456; done=1, error=0.
REQ-035 start; bytes 02,AA,BB,CC,11,22,33, checksum DF -> writes 0x00=0xAABBCC, 0x01=0x112233; done=1.
REQ-036 start; bytes 01,00,00,00, checksum 00 -> write 0x00=0x000000; error=1, done=0.
REQ-037 start; bytes 00, checksum 00 -> no writes; done=1.
REQ-038 REQ-034 stream with 3-cycle in_valid gaps, plus bytes driven in IDLE beforehand -> identical writes and status; IDLE bytes ignored.
REQ-039 rst low after the second data byte of REQ-035 -> no write, all outputs 0; rerun of REQ-034 -> write at addr 0x00, done=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared CPU package: instruction-word geometry and the program-loader
// state encoding, also imported by the ROM and decoder blocks.
package prog_loader_pkg;

    // Default bytes per instruction word and the resulting word width
    localparam int INSTR_BYTES_DEF = 3;
    localparam int INSTR_W         = 8 * INSTR_BYTES_DEF;

    // Program-loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEN   = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } load_state_t;

    // Running checksum over the byte stream (length and payload bytes)
    function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                               input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-to-word packer: counts bytes within the current instruction word and
// shifts them in MSB-first, flagging the byte that completes a word.
module prog_packer #(
    parameter int INSTR_BYTES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     byte_en,
    input  logic [7:0]               byte_data,
    output logic [8*INSTR_BYTES-1:0] word_next,
    output logic                     word_complete
);

    localparam int WORD_W = 8 * INSTR_BYTES;
    localparam int IDX_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;

    // The first byte ends up in the top byte lane after INSTR_BYTES shifts
    assign word_next     = (word << 8) | WORD_W'(byte_data);
    assign word_complete = byte_en && (idx == LAST_IDX);

    // Byte index and partial-word register; cleared at the start of a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (byte_en) begin
            word <= word_next;
            idx  <= word_complete ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length byte, N instruction words as a byte
// stream and a trailing XOR checksum byte, writing each assembled word into
// instruction memory at consecutive addresses starting from 0.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     mem_w_enable,
    output logic [ADDR_W-1:0]        mem_w_addr,
    output logic [8*INSTR_BYTES-1:0] mem_w_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int WORD_W = 8 * INSTR_BYTES;

    load_state_t       state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        csum;
    logic [7:0]        words_left;

    logic              accept;
    logic              pack_en;
    logic              pack_clear;
    logic [WORD_W-1:0] word_next;
    logic              word_complete;

    assign accept     = in_valid && in_ready;
    assign pack_en    = accept && (state == ST_DATA);
    assign pack_clear = (state == ST_IDLE) && start;

    prog_packer #(
        .INSTR_BYTES (INSTR_BYTES)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear         (pack_clear),
        .byte_en       (pack_en),
        .byte_data     (in_data),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    // Load sequencer: all outputs registered; the write strobe is a
    // one-cycle pulse issued the cycle after a word's final byte, while
    // in_ready stays high so the next word can keep streaming in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_w_addr   <= '0;
            mem_w_data   <= '0;
            addr_cnt     <= '0;
            csum         <= '0;
            words_left   <= '0;
        end else begin
            mem_w_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LEN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        addr_cnt <= '0;
                        csum     <= '0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        words_left <= in_data;
                        csum       <= csum_update(csum, in_data);
                        state      <= (in_data == 8'd0) ? ST_CHECK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum <= csum_update(csum, in_data);
                        if (word_complete) begin
                            mem_w_enable <= 1'b1;
                            mem_w_addr   <= addr_cnt;
                            mem_w_data   <= word_next;
                            addr_cnt     <= addr_cnt + ADDR_W'(1);
                            words_left   <= words_left - 8'd1;
                            if (words_left == 8'd1) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of load streams with expected writes and
// status, plus a mid-load reset sequence.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_w_enable;
    logic [7:0]  mem_w_addr;
    logic [23:0] mem_w_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  wr_addr_q[$];
    logic [23:0] wr_data_q[$];

    typedef struct packed {
        logic [3:0]        nbytes;
        logic [0:7][7:0]   bytes;
        logic [3:0]        gap;
        logic              idle_noise;
        logic              mid_start;
        logic [1:0]        nwr;
        logic [0:1][7:0]   waddr;
        logic [0:1][23:0]  wdata;
        logic              exp_done;
        logic              exp_error;
    } vec_t;

    vec_t vecs[6];

    prog_loader #(
        .ADDR_W      (8),
        .INSTR_BYTES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_w_enable (mem_w_enable),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Capture every memory write strobe
    always @(negedge clk) begin
        if (mem_w_enable) begin
            wr_addr_q.push_back(mem_w_addr);
            wr_data_q.push_back(mem_w_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            check("in_ready_timeout", 32'(waits), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input int v, input vec_t t);
        wr_addr_q.delete();
        wr_data_q.delete();
        if (t.idle_noise) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'hE5 + 8'(k);
                check($sformatf("v%0d_idle_ready", v), 32'(in_ready), 32'd0);
            end
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_idle_nowrite", v), 32'(wr_addr_q.size()), 32'd0);
        end
        pulse_start();
        check($sformatf("v%0d_start_busy", v), 32'(busy), 32'd1);
        check($sformatf("v%0d_start_done", v), 32'(done), 32'd0);
        check($sformatf("v%0d_start_error", v), 32'(error), 32'd0);
        for (int i = 0; i < int'(t.nbytes); i++) begin
            send_byte(t.bytes[i], int'(t.gap));
            if (i == 0 && t.mid_start) pulse_start();
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_nwrites", v), 32'(wr_addr_q.size()), 32'(t.nwr));
        for (int i = 0; i < int'(t.nwr); i++) begin
            if (i < wr_addr_q.size()) begin
                check($sformatf("v%0d_waddr%0d", v, i), 32'(wr_addr_q[i]), 32'(t.waddr[i]));
                check($sformatf("v%0d_wdata%0d", v, i), 32'(wr_data_q[i]), 32'(t.wdata[i]));
            end
        end
        check($sformatf("v%0d_done", v), 32'(done), 32'(t.exp_done));
        check($sformatf("v%0d_error", v), 32'(error), 32'(t.exp_error));
        check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
        check($sformatf("v%0d_ready", v), 32'(in_ready), 32'd0);
    endtask

    initial begin
        // Single word, good checksum 01^12^34^56 = 71
        vecs[0] = '{nbytes: 4'd5, bytes: {8'h01, 8'h12, 8'h34, 8'h56, 8'h71, 8'h00, 8'h00, 8'h00},
                    gap: 4'd0, idle_noise: 1'b0, mid_start: 1'b0, nwr: 2'd1,
                    waddr: {8'h00, 8'h00}, wdata: {24'h123456, 24'h000000},
                    exp_done: 1'b1, exp_error: 1'b0};
        // Two words, good checksum DF
        vecs[1] = '{nbytes: 4'd8, bytes: {8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'hDF},
                    gap: 4'd0, idle_noise: 1'b0, mid_start: 1'b0, nwr: 2'd2,
                    waddr: {8'h00, 8'h01}, wdata: {24'hAABBCC, 24'h112233},
                    exp_done: 1'b1, exp_error: 1'b0};
        // Bad checksum (running XOR is 01, sent 00): write still happens
        vecs[2] = '{nbytes: 4'd5, bytes: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    gap: 4'd0, idle_noise: 1'b0, mid_start: 1'b0, nwr: 2'd1,
                    waddr: {8'h00, 8'h00}, wdata: {24'h000000, 24'h000000},
                    exp_done: 1'b0, exp_error: 1'b1};
        // Zero-length load
        vecs[3] = '{nbytes: 4'd2, bytes: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    gap: 4'd0, idle_noise: 1'b0, mid_start: 1'b0, nwr: 2'd0,
                    waddr: {8'h00, 8'h00}, wdata: {24'h000000, 24'h000000},
                    exp_done: 1'b1, exp_error: 1'b0};
        // Vector 0 with 3-cycle gaps and bytes driven while idle
        vecs[4] = vecs[0];
        vecs[4].gap = 4'd3;
        vecs[4].idle_noise = 1'b1;
        // Vector 1 with a start pulse in the middle of the load
        vecs[5] = vecs[1];
        vecs[5].mid_start = 1'b1;

        // Reset state
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wen", 32'(mem_w_enable), 32'd0);
        check("rst_waddr", 32'(mem_w_addr), 32'd0);
        check("rst_wdata", 32'(mem_w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_vec(v, vecs[v]);
        end

        // Reset after the second data byte of a two-word load
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_wen", 32'(mem_w_enable), 32'd0);
        check("mrst_waddr", 32'(mem_w_addr), 32'd0);
        check("mrst_wdata", 32'(mem_w_data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        repeat (3) @(negedge clk);
        check("mrst_nowrite", 32'(wr_addr_q.size()), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(6, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
